// File: rtl/rx_arbiter.sv
// Four-channel receive arbiter: captures bytes on ch_ready rises, presents them
// round-robin on a valid/ready output, and tracks overruns and framing-error events.
`timescale 1ns/1ps

module rx_arbiter #(
    parameter int ERRW = 8
) (
    input  logic            clk,
    input  logic            gl_reset_n,
    input  logic [31:0]     ch_data,
    input  logic [3:0]      ch_ready,
    input  logic [3:0]      ch_error,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [7:0]      out_data,
    output logic [1:0]      out_chan,
    output logic [3:0]      overrun,
    output logic [ERRW-1:0] err_count,
    input  logic            clr
);

    typedef enum logic {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } state_t;

    state_t          state;
    state_t          state_next;

    logic [3:0]      prev_rdy;
    logic [3:0]      prev_err;
    logic [3:0]      rdy_rise;
    logic [3:0]      err_rise;
    logic [3:0]      pend;
    logic [3:0]      pend_next;
    logic [3:0]      granted_mask;
    logic [3:0]      ovr_set;
    logic [7:0]      hold [4];
    logic [1:0]      last_grant;
    logic [1:0]      sel;
    logic [1:0]      cand;
    logic            found;
    logic            grant;
    logic [2:0]      err_rises;
    logic [ERRW+2:0] err_sum;
    logic [ERRW-1:0] err_next;

    assign rdy_rise = ch_ready & ~prev_rdy;
    assign err_rise = ch_error & ~prev_err;

    // Round-robin pick: first pending channel after last_grant, wrapping mod 4.
    always_comb begin
        // NOTE: every variable driven here gets a default first, so no path can infer a latch.
        sel   = last_grant;
        cand  = '0;
        found = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            cand = last_grant + 2'(k);
            if (!found && pend[cand]) begin
                sel   = cand;
                found = 1'b1;
            end
        end
    end

    always_comb begin
        state_next = state;
        grant      = 1'b0;
        case (state)
            IDLE: begin
                if (|pend) begin
                    grant      = 1'b1;
                    state_next = PRESENT;
                end
            end
            PRESENT: begin
                if (out_ready) begin
                    if (|pend) grant = 1'b1;
                    else       state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // A channel granted on the edge it recaptures keeps pend and does not overrun.
    always_comb begin
        granted_mask = grant ? (4'b0001 << sel) : 4'b0000;
        pend_next    = (pend & ~granted_mask) | rdy_rise;
        ovr_set      = rdy_rise & pend & ~granted_mask;
    end

    always_comb begin
        err_rises = 3'(err_rise[0]) + 3'(err_rise[1]) + 3'(err_rise[2]) + 3'(err_rise[3]);
        err_sum   = {3'b000, err_count} + {{ERRW{1'b0}}, err_rises};
        if (err_sum > {3'b000, {ERRW{1'b1}}}) err_next = '1;
        else                                   err_next = err_sum[ERRW-1:0];
    end

    always_ff @(posedge clk or negedge gl_reset_n) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!gl_reset_n) state <= IDLE;
        else             state <= state_next;
    end

    assign out_valid = (state == PRESENT);

    always_ff @(posedge clk or negedge gl_reset_n) begin
        if (!gl_reset_n) begin
            // NOTE: the small hold array is reset on purpose so no stale byte can leak after reset.
            for (int i = 0; i < 4; i++) hold[i] <= '0;
            prev_rdy   <= 4'b1111;
            prev_err   <= 4'b1111;
            pend       <= '0;
            overrun    <= '0;
            err_count  <= '0;
            last_grant <= 2'd3;
            out_data   <= '0;
            out_chan   <= '0;
        end else begin
            prev_rdy <= ch_ready;
            prev_err <= ch_error;
            pend     <= pend_next;
            for (int i = 0; i < 4; i++) begin
                if (rdy_rise[i]) hold[i] <= ch_data[8*i +: 8];
            end
            if (grant) begin
                out_data   <= hold[sel];
                out_chan   <= sel;
                last_grant <= sel;
            end
            if (clr) begin
                overrun   <= '0;
                err_count <= '0;
            end else begin
                overrun   <= overrun | ovr_set;
                err_count <= err_next;
            end
        end
    end

endmodule

// File: doc/rx_arbiter.md
RX_ARBITER -- requirements
Module: rx_arbiter

Interface
REQ-001 Parameter ERRW, default 8, width of the saturating error counter.
REQ-002 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 gl_reset_n  input  1  asynchronous, active-low reset.
REQ-004 ch_data  input  32  received byte per channel; channel i occupies bits [8i+7:8i] (dOut of four receivers).
REQ-005 ch_ready  input  4  per-channel data-ready level (dReady); stays high until that receiver's next start.
REQ-006 ch_error  input  4  per-channel framing-error level (dError).
REQ-007 out_valid  output  1  out_data/out_chan hold a byte for the consumer.
REQ-008 out_ready  input  1  consumer accepts the byte when high with out_valid.
REQ-009 out_data  output  8  granted byte.
REQ-010 out_chan  output  2  channel index of out_data.
REQ-011 overrun  output  4  sticky per-channel overrun flags.
REQ-012 err_count  output  ERRW  saturating count of error events, all channels.
REQ-013 clr  input  1  synchronous clear of overrun and err_count.

Function
REQ-014 The block SHALL register ch_ready and ch_error each cycle (prev_rdy, prev_err). A rise is current=1 with prev=0.
REQ-015 On a ch_ready[i] rise, the block SHALL copy ch_data byte i into hold[i] and set pend[i] at that clock edge.
REQ-016 If pend[i] is already set and is not being granted at that edge, the new byte SHALL overwrite hold[i] (newest wins) and overrun[i] SHALL set.
REQ-017 If a capture and a grant of channel i fall on the same edge, the old byte SHALL go to the output. The new byte SHALL go to hold[i] with pend[i] left at 1, and overrun[i] SHALL NOT set.
REQ-018 Each ch_error rise SHALL add 1 to err_count. Simultaneous rises SHALL add the number of rising bits. The result SHALL saturate at 2^ERRW-1 with no wrap.
REQ-019 When clr=1, overrun SHALL go to 0 and err_count SHALL go to 0. Clr takes precedence over any same-cycle set or increment.
REQ-020 The arbiter FSM SHALL have two states, IDLE and PRESENT.
REQ-021 IDLE, any pend=1: select a channel round-robin, searching from last_grant+1 upward modulo 4.
  - Load out_data=hold[sel] and out_chan=sel.
  - Clear pend[sel], update last_grant=sel, assert out_valid, go to PRESENT.
REQ-022 IDLE, no pend: out_valid=0 and the FSM stays in IDLE.
REQ-023 PRESENT with out_ready=0: out_valid, out_data and out_chan SHALL remain stable.
REQ-024 PRESENT with out_ready=1 and another pend set: the next grant SHALL load on the same edge (back-to-back, no idle bubble).
REQ-025 PRESENT with out_ready=1 and no pend set: out_valid SHALL deassert and the FSM SHALL return to IDLE.
REQ-026 Latency: a ch_ready rise sampled at edge t SHALL give out_valid=1 after edge t+1 when the FSM is idle.
REQ-027 Throughput: one byte per cycle while out_ready is held high.
REQ-028 A channel not yet accepted SHALL keep its pend. Round-robin SHALL prevent starvation: any pending channel is granted within 4 grants.

Reset
REQ-029 On gl_reset_n=0 the block SHALL reset immediately, independent of clk:
  - FSM=IDLE, out_valid=0, out_data=0, out_chan=0.
  - pend=0, hold=0, overrun=0, err_count=0.
  - last_grant=3, so channel 0 has first priority.
  - prev_rdy=4'b1111 and prev_err=4'b1111, so levels already high at release are not captured.
REQ-030 Reset asserted mid-transfer SHALL discard all pending and presented bytes. After release, a channel SHALL capture only after its ch_ready has been seen low and then high.
REQ-031 Reset release SHALL be usable synchronously to clk. The first active edge after release SHALL behave as a normal cycle.

Verification
REQ-032 Reset release with ch_ready=4'b0001 held high -> no capture, out_valid stays 0. Then ch_ready[0] goes 0 then 1 with byte 0xA5 -> out_valid=1, out_data=0xA5, out_chan=0 two edges after the rise.
REQ-033 ch_ready rises on all four channels in one cycle with bytes 0x11/0x22/0x33/0x44, out_ready=1 -> four consecutive valid cycles, channel order 0,1,2,3. Then a single new rise on channel 0 -> next grant goes to channel 0.
REQ-034 out_ready=0 while ch1 presents 0x5A, and ch1 rises twice more (0x6B, then 0x7C) -> out_data stays 0x5A. overrun=4'b0010 after the second rise. Once out_ready=1, the next byte from ch1 is 0x7C.
REQ-035 ch1 is granted on the same edge that ch1 captures 0x99 -> no overrun, and 0x99 is presented next.
REQ-036 ERRW=2; ch_error rises on 3 channels at once, then on 1 more -> err_count goes 3 then stays 3. clr=1 together with a rise -> err_count=0.
REQ-037 gl_reset_n pulsed low mid-clock while out_valid=1 and pend=4'b1010 -> all outputs 0 without waiting for a clock edge, and no stale byte appears after release.
